rex_game_ctrl: RTL and testbench

REX_GAME_CTRL -- requirements
Module: rex_game_ctrl

---
 rtl/rex_pkg.sv | 48 ++++
 rtl/rex_debounce.sv | 52 +++++
 rtl/rex_game_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rex_game_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rex_pkg.sv
// Shared definitions for the rex game: state codes, Ld bit positions and
// button indices, reused by the controller and the VGA renderer.
package rex_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_JUMP  = 3'd2,
    ST_DUCK  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DEAD  = 3'd5
  } rex_state_e;

  localparam int LD_INIT  = 0;
  localparam int LD_RUN   = 1;
  localparam int LD_JUMP  = 2;
  localparam int LD_DUCK  = 3;
  localparam int LD_PAUSE = 4;
  localparam int LD_DEAD  = 5;

  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 0;
  localparam int BTN_JUMP  = 1;
  localparam int BTN_DUCK  = 2;
  localparam int BTN_PAUSE = 3;

  // One-hot Ld pattern for a state.
  function automatic logic [5:0] state_to_ld(rex_state_e s);
    logic [5:0] ld;
    ld = '0;
    case (s)
      ST_INIT:  ld[LD_INIT]  = 1'b1;
      ST_RUN:   ld[LD_RUN]   = 1'b1;
      ST_JUMP:  ld[LD_JUMP]  = 1'b1;
      ST_DUCK:  ld[LD_DUCK]  = 1'b1;
      ST_PAUSE: ld[LD_PAUSE] = 1'b1;
      ST_DEAD:  ld[LD_DEAD]  = 1'b1;
      default:  ld = '0;
    endcase
    return ld;
  endfunction

  // States in which the game world moves (divider counts, score grows).
  function automatic logic is_active(rex_state_e s);
    return (s == ST_RUN) || (s == ST_JUMP) || (s == ST_DUCK);
  endfunction

endpackage

// File: rtl/rex_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debouncer and a
// registered one-cycle pulse on the debounced rising edge.
module rex_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then flip the level once the input has disagreed with it
  // for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/rex_game_ctrl.sv
// Rex runner game controller: button conditioning, game FSM, move-tick
// divider, jump arc, score and high score.
module rex_game_ctrl
  import rex_pkg::*;
#(
  parameter int DIV_W      = 20,
  parameter int JUMP_TICKS = 16,
  parameter int SCORE_W    = 16,
  parameter int DEB_CYCLES = 65536
) (
  input  logic                          ClkPort,
  input  logic                          Reset,
  input  logic                          BtnStart,
  input  logic                          BtnJump,
  input  logic                          BtnDuck,
  input  logic                          BtnPause,
  input  logic                          Collide,
  output logic [5:0]                    Ld,
  output logic                          move_tick,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            hi_score,
  output logic [$clog2(JUMP_TICKS)-1:0] jump_height
);

  localparam int JC_W = $clog2(JUMP_TICKS);
  localparam logic [JC_W-1:0] JC_LAST = JC_W'(JUMP_TICKS - 1);
  localparam logic [JC_W-1:0] JC_HALF = JC_W'(JUMP_TICKS / 2);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_unused;

  rex_state_e         r_state;
  rex_state_e         r_saved;
  rex_state_e         w_state_next;
  rex_state_e         w_saved_next;
  rex_state_e         w_motion;
  logic [DIV_W-1:0]   r_div;
  logic [JC_W-1:0]    r_jump_cnt;
  logic [JC_W-1:0]    w_jc_next;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_hi_score;
  logic               w_tick;
  logic               w_clear_score;
  logic               w_enter_dead;

  assign w_btn_raw = {BtnPause, BtnDuck, BtnJump, BtnStart};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      rex_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .i_clk   (ClkPort),
        .i_srst  (Reset),
        .i_btn   (w_btn_raw[gi]),
        .o_level (w_level[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  // Duck acts on its level; the others act only on their rising-edge pulse.
  assign w_unused = ^{w_level[BTN_START], w_level[BTN_JUMP],
                      w_level[BTN_PAUSE], w_rise[BTN_DUCK]};

  // A tick is the last divider count, only while the world is moving.
  assign w_tick = is_active(r_state) && (r_div == '1);

  // State register plus the state to resume when leaving PAUSE.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_state <= ST_INIT;
      r_saved <= ST_RUN;
    end else begin
      r_state <= w_state_next;
      r_saved <= w_saved_next;
    end
  end

  // Next state with Collide > Pause > Jump > Duck. A tick in the pause
  // cycle still advances the jump, so the saved state reflects that step.
  always_comb begin
    w_state_next  = r_state;
    w_saved_next  = r_saved;
    w_motion      = r_state;
    w_jc_next     = r_jump_cnt;
    w_clear_score = 1'b0;
    w_enter_dead  = 1'b0;
    case (r_state)
      ST_INIT, ST_DEAD: begin
        if (w_rise[BTN_START]) begin
          w_state_next  = ST_RUN;
          w_clear_score = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_rise[BTN_PAUSE]) w_state_next = r_saved;
      end
      ST_RUN, ST_JUMP, ST_DUCK: begin
        if (Collide) begin
          w_state_next = ST_DEAD;
          w_enter_dead = 1'b1;
        end else begin
          if (r_state == ST_JUMP && w_tick) begin
            if (r_jump_cnt == JC_LAST) begin
              w_motion  = ST_RUN;
              w_jc_next = '0;
            end else begin
              w_jc_next = r_jump_cnt + 1'b1;
            end
          end
          if (w_rise[BTN_PAUSE]) begin
            w_state_next = ST_PAUSE;
            w_saved_next = w_motion;
          end else if (r_state == ST_JUMP) begin
            w_state_next = w_motion;
          end else if (w_rise[BTN_JUMP]) begin
            w_state_next = ST_JUMP;
            w_jc_next    = '0;
          end else if (r_state == ST_RUN && w_level[BTN_DUCK]) begin
            w_state_next = ST_DUCK;
          end else if (r_state == ST_DUCK && !w_level[BTN_DUCK]) begin
            w_state_next = ST_RUN;
          end
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  // Outputs decoded straight from registers.
  always_comb begin
    Ld          = state_to_ld(r_state);
    move_tick   = w_tick;
    jump_height = '0;
    if (r_state == ST_JUMP || (r_state == ST_PAUSE && r_saved == ST_JUMP)) begin
      jump_height = (r_jump_cnt < JC_HALF) ? r_jump_cnt : (JC_LAST - r_jump_cnt);
    end
  end

  // Divider runs while moving, freezes in PAUSE, clears otherwise.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_div      <= '0;
      r_jump_cnt <= '0;
    end else begin
      r_jump_cnt <= w_jc_next;
      if (is_active(r_state)) begin
        r_div <= r_div + 1'b1;
      end else if (r_state != ST_PAUSE) begin
        r_div <= '0;
      end
    end
  end

  // Saturating score; the collision cycle does not score, and the high
  // score captures the final value on the way into DEAD.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_score    <= '0;
      r_hi_score <= '0;
    end else begin
      if (w_clear_score) begin
        r_score <= '0;
      end else if (w_tick && !Collide && r_score != '1) begin
        r_score <= r_score + 1'b1;
      end
      if (w_enter_dead && r_score > r_hi_score) begin
        r_hi_score <= r_score;
      end
    end
  end

  assign score    = r_score;
  assign hi_score = r_hi_score;

endmodule

// File: tb/tb_rex_game_ctrl.sv
// Self-checking bench for rex_game_ctrl with small parameters: a vector
// table, directed corner sequences and random stimulus against a model.
module tb_rex_game_ctrl;

  localparam int DIV_W = 2;
  localparam int JT    = 4;
  localparam int SW    = 4;
  localparam int DEB   = 2;
  localparam int DMAX  = (1 << DIV_W) - 1;
  localparam int SMAX  = (1 << SW) - 1;

  // Ld bit positions as named by the interface.
  localparam int M_INIT = 0, M_RUN = 1, M_JUMP = 2, M_DUCK = 3, M_PAUSE = 4, M_DEAD = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          b_start, b_jump, b_duck, b_pause, coll;
  logic [5:0]    ld;
  logic          mt;
  logic [SW-1:0] sc, hs;
  logic [1:0]    jh;

  always #5 clk = ~clk;

  rex_game_ctrl #(.DIV_W(DIV_W), .JUMP_TICKS(JT), .SCORE_W(SW), .DEB_CYCLES(DEB)) dut (
    .ClkPort     (clk),
    .Reset       (rst),
    .BtnStart    (b_start),
    .BtnJump     (b_jump),
    .BtnDuck     (b_duck),
    .BtnPause    (b_pause),
    .Collide     (coll),
    .Ld          (ld),
    .move_tick   (mt),
    .score       (sc),
    .hi_score    (hs),
    .jump_height (jh)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_mode, m_saved, m_jc, m_div, m_score, m_hi;
  int m_s0[4], m_s1[4], m_lvl[4], m_run[4], m_pul[4];

  task automatic chk(string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected event (t=%0t)", nm, $time);
  endtask

  function automatic int exp_height();
    if (m_mode == M_JUMP || (m_mode == M_PAUSE && m_saved == M_JUMP))
      return (m_jc < JT / 2) ? m_jc : (JT - 1 - m_jc);
    return 0;
  endfunction

  function automatic bit moving();
    return (m_mode == M_RUN) || (m_mode == M_JUMP) || (m_mode == M_DUCK);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit [3:0] rb;
    bit tick, p_st, p_jp, p_ps, dk;
    int n_mode, n_saved, n_jc, n_div, n_score, n_hi, tgt, sv;
    rb = {b_pause, b_duck, b_jump, b_start};
    if (rst) begin
      m_mode = M_INIT; m_saved = M_RUN; m_jc = 0; m_div = 0; m_score = 0; m_hi = 0;
      for (int i = 0; i < 4; i++) begin
        m_s0[i] = 0; m_s1[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_pul[i] = 0;
      end
      return;
    end
    tick = moving() && (m_div == DMAX);
    p_st = (m_pul[0] != 0); p_jp = (m_pul[1] != 0); dk = (m_lvl[2] != 0); p_ps = (m_pul[3] != 0);
    n_mode = m_mode; n_saved = m_saved; n_jc = m_jc; n_score = m_score; n_hi = m_hi;
    if (moving())               n_div = (m_div + 1) % (DMAX + 1);
    else if (m_mode == M_PAUSE) n_div = m_div;
    else                        n_div = 0;
    if (m_mode == M_INIT || m_mode == M_DEAD) begin
      if (p_st) begin n_mode = M_RUN; n_score = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (p_ps) n_mode = m_saved;
    end else if (coll) begin
      n_mode = M_DEAD;
      if (m_score > m_hi) n_hi = m_score;
    end else begin
      if (tick && m_score < SMAX) n_score = m_score + 1;
      tgt = m_mode;
      if (m_mode == M_JUMP && tick) begin
        if (m_jc == JT - 1) begin tgt = M_RUN; n_jc = 0; end
        else n_jc = m_jc + 1;
      end
      if (p_ps) begin n_mode = M_PAUSE; n_saved = tgt; end
      else if (m_mode == M_JUMP) n_mode = tgt;
      else if (p_jp) begin n_mode = M_JUMP; n_jc = 0; end
      else if (m_mode == M_RUN && dk) n_mode = M_DUCK;
      else if (m_mode == M_DUCK && !dk) n_mode = M_RUN;
    end
    // Buttons: two-sample delay, then level follows after DEB disagreeing samples.
    for (int i = 0; i < 4; i++) begin
      sv = m_s1[i];
      m_pul[i] = 0;
      if (sv != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_lvl[i] = sv; m_run[i] = 0; m_pul[i] = sv; end
      end else begin
        m_run[i] = 0;
      end
      m_s1[i] = m_s0[i];
      m_s0[i] = int'(rb[i]);
    end
    m_mode = n_mode; m_saved = n_saved; m_jc = n_jc; m_div = n_div; m_score = n_score; m_hi = n_hi;
  endtask

  task automatic model_check();
    chk("ld", ld, 1 << m_mode);
    chk("move_tick", mt, (moving() && m_div == DMAX) ? 1 : 0);
    chk("score", sc, m_score);
    chk("hi_score", hs, m_hi);
    chk("jump_height", jh, exp_height());
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic run_until_mode(int mode, int max_cyc, string nm);
    int i;
    i = 0;
    while (m_mode != mode && i < max_cyc) begin
      step();
      i++;
    end
    chk(nm, ld, 1 << mode);
  endtask

  typedef struct {
    bit st; bit jp; bit dk; bit ps; bit co;
    int cyc; int e_ld; int e_sc; int e_hi; int e_jh;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int s_frz;
    int wi;
    int hold[4];
    bit [3:0] rb;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10,  2, 1, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4,  2, 2, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1,  2, 2, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  5,  2, 3, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  4,  2, 4, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1,  4, 5, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4,  4, 6, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4,  4, 7, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4,  4, 8, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  4,  2, 9, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 32, 9, 9, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, 32, 9, 9, 0};

    rst = 1'b1; b_start = 0; b_jump = 0; b_duck = 0; b_pause = 0; coll = 0;
    step();
    step();
    chk("reset_ld", ld, 1);
    chk("reset_tick", mt, 0);
    chk("reset_score", sc, 0);
    chk("reset_hi", hs, 0);
    chk("reset_jh", jh, 0);
    rst = 1'b0;

    // Vector table: start, glitch, full jump arc, collision.
    for (int k = 0; k < 12; k++) begin
      b_start = tbl[k].st; b_jump = tbl[k].jp; b_duck = tbl[k].dk;
      b_pause = tbl[k].ps; coll = tbl[k].co;
      repeat (tbl[k].cyc) step();
      chk($sformatf("vec%0d_ld", k), ld, tbl[k].e_ld);
      chk($sformatf("vec%0d_score", k), sc, tbl[k].e_sc);
      chk($sformatf("vec%0d_hi", k), hs, tbl[k].e_hi);
      chk($sformatf("vec%0d_jh", k), jh, tbl[k].e_jh);
    end
    coll = 0;

    // Reset while ducking.
    b_start = 1; repeat (4) step(); b_start = 0;
    run_until_mode(M_RUN, 5, "duck_seq_run");
    b_duck = 1;
    run_until_mode(M_DUCK, 10, "duck_seq_duck");
    rst = 1; step();
    chk("duck_rst_ld", ld, 1);
    chk("duck_rst_tick", mt, 0);
    chk("duck_rst_score", sc, 0);
    chk("duck_rst_hi", hs, 0);
    chk("duck_rst_jh", jh, 0);
    rst = 0; b_duck = 0;

    // Collide, Jump and Pause in one cycle at score 5.
    b_start = 1; repeat (4) step(); b_start = 0;
    run_until_mode(M_RUN, 5, "prio_run");
    wi = 0;
    while (!(m_score == 4 && m_div == 0) && wi < 100) begin step(); wi++; end
    if (wi >= 100) timeout_fail("prio_wait_score4");
    b_jump = 1; b_pause = 1; repeat (4) step(); b_jump = 0; b_pause = 0;
    coll = 1; step(); coll = 0;
    chk("prio_ld", ld, 32);
    chk("prio_score", sc, 5);
    chk("prio_hi", hs, 5);
    b_start = 1; repeat (4) step(); b_start = 0;
    run_until_mode(M_RUN, 5, "restart_run");
    chk("restart_score", sc, 0);
    chk("restart_hi", hs, 5);

    // Pause in the middle of a jump.
    b_jump = 1; repeat (4) step(); b_jump = 0;
    run_until_mode(M_JUMP, 5, "pj_jump");
    wi = 0;
    while (!(m_jc == 1 && m_div == 0) && wi < 40) begin step(); wi++; end
    if (wi >= 40) timeout_fail("pj_wait_jc1");
    b_pause = 1; repeat (4) step(); b_pause = 0;
    step();
    chk("pj_paused_ld", ld, 16);
    s_frz = m_score;
    repeat (20) step();
    chk("pj_frozen_score", sc, s_frz);
    chk("pj_frozen_jh", jh, 1);
    b_pause = 1; repeat (4) step(); b_pause = 0;
    run_until_mode(M_JUMP, 5, "pj_resume_ld");
    chk("pj_resume_jh", jh, 1);
    chk("pj_resume_score", sc, s_frz);

    // Score saturation.
    repeat (80) step();
    chk("sat_score", sc, SMAX);

    // Random buttons, collisions and occasional resets.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          rb[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      b_start = rb[0]; b_jump = rb[1]; b_duck = rb[2]; b_pause = rb[3];
      coll = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 0; coll = 0; b_start = 0; b_jump = 0; b_duck = 0; b_pause = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
